// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for data_cache.
// slave is the cache's view; master is the view of the CPU plus backing memory.
interface data_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  stall_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [31:0]           hit_cnt_o;
  logic [31:0]           miss_cnt_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, flush_i, mem_ack_i, mem_rdata_i,
    output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           hit_cnt_o, miss_cnt_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, flush_i, mem_ack_i, mem_rdata_i,
    input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines,
// stalling the CPU on load misses and on every store, plus hit/miss counters.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LINES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_e;

  state_e state_q, state_d;

  logic                  valid_q [NUM_LINES];
  logic [TAG_W-1:0]      tag_q   [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q  [NUM_LINES];
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  fill;
  logic                  store_hit;
  logic                  unused_addr_lsbs;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;

  assign idx              = bus.addr_i[IDX_W+1:2];
  assign tag              = bus.addr_i[ADDR_WIDTH-1:IDX_W+2];
  assign hit              = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr_lsbs = ^bus.addr_i[1:0];

  // A flush coinciding with the fill ack suppresses the fill entirely.
  assign fill      = (state_q == RD_MISS) && bus.mem_ack_i && !bus.flush_i;
  assign store_hit = (state_q == IDLE) && bus.req_i && bus.we_i && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) valid_q[i] <= 1'b0;
    end else if (bus.flush_i) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) valid_q[i] <= 1'b0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validity alone gates their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.mem_rdata_i;
    end else if (store_hit) begin
      data_q[idx] <= bus.wdata_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (bus.we_i) begin
            state_d = WR_THRU;
          end else if (hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            state_d    = RD_MISS;
            miss_cnt_d = miss_cnt_q + 32'd1;
          end
        end
      end
      RD_MISS: if (bus.mem_ack_i) state_d = IDLE;
      WR_THRU: if (bus.mem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata   = '0;
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (!bus.we_i && hit) rdata = data_q[idx];
          else                  stall = 1'b1;
        end
      end
      RD_MISS: begin
        mem_req = 1'b1;
        stall   = !bus.mem_ack_i;
        if (bus.mem_ack_i) rdata = bus.mem_rdata_i;
      end
      WR_THRU: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = !bus.mem_ack_i;
      end
      default: ;
    endcase
  end

  assign bus.rdata_o     = rdata;
  assign bus.stall_o     = stall;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata_o = bus.wdata_i;
  assign bus.hit_cnt_o   = hit_cnt_q;
  assign bus.miss_cnt_o  = miss_cnt_q;
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios then random accesses against a
// line-array and word-memory reference model, with the bench acting as memory.
module tb_data_cache;
  localparam int NL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_LINES(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: cache lines indexed by word address mod NL, plus memory words.
  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  logic [31:0] m_data  [NL];
  logic [31:0] mem     [int unsigned];
  logic [31:0] m_hits  = '0;
  logic [31:0] m_miss  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int unsigned wa);
    return mem.exists(wa) ? mem[wa] : (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic idle(input bit flush);
    @(negedge clk);
    bus.req_i = 1'b0; bus.mem_ack_i = 1'b0; bus.flush_i = flush;
    bus.addr_i = $urandom; bus.we_i = $urandom_range(0, 1);
    #1;
    chk("idle_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("idle_rdata", bus.rdata_o, 32'd0);
    chk("idle_memreq", {31'd0, bus.mem_req_o}, 32'd0);
    chk("hit_cnt", bus.hit_cnt_o, m_hits);
    chk("miss_cnt", bus.miss_cnt_o, m_miss);
    @(posedge clk);
    if (flush) model_flush();
  endtask

  // One CPU access; lat is the memory ack latency in cycles if memory is used.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input bit flush_at_ack);
    int unsigned wa  = addr >> 2;
    int unsigned idx = wa % NL;
    int unsigned tg  = wa / NL;
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    logic [31:0] rd;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wd;
    bus.flush_i = 1'b0; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = $urandom;
    #1;
    chk("lookup_memreq", {31'd0, bus.mem_req_o}, 32'd0);
    if (!we && hit) begin
      chk("hit_stall", {31'd0, bus.stall_o}, 32'd0);
      chk("hit_rdata", bus.rdata_o, m_data[idx]);
      @(posedge clk);
      m_hits++;
      return;
    end
    chk("lookup_stall", {31'd0, bus.stall_o}, 32'd1);
    @(posedge clk);
    if (we && hit) m_data[idx] = wd;
    if (!we) m_miss++;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      bus.mem_ack_i = (n == lat);
      bus.flush_i   = (n == lat) && flush_at_ack;
      rd            = mem_rd(wa);
      bus.mem_rdata_i = (n == lat) ? rd : $urandom;
      #1;
      chk("mem_req", {31'd0, bus.mem_req_o}, 32'd1);
      chk("mem_we", {31'd0, bus.mem_we_o}, {31'd0, we});
      chk("mem_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
      chk("miss_stall", {31'd0, bus.stall_o}, (n == lat) ? 32'd0 : 32'd1);
      if (we) chk("mem_wdata", bus.mem_wdata_o, wd);
      if (!we && n == lat) chk("miss_rdata", bus.rdata_o, rd);
      @(posedge clk);
    end
    if (we) mem[wa] = wd;
    if (flush_at_ack) model_flush();
    else if (!we) begin
      m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = mem_rd(wa);
    end
    @(negedge clk);
    bus.flush_i = 1'b0; bus.mem_ack_i = 1'b0; bus.req_i = 1'b0;
  endtask

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.flush_i = 1'b0; bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    model_flush();
    mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    #1;
    chk("rst_memreq", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_memwe", {31'd0, bus.mem_we_o}, 32'd0);
    chk("rst_hits", bus.hit_cnt_o, 32'd0);
    chk("rst_miss", bus.miss_cnt_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1'b0);

    // Fill, hit, store-hit, hit on new data.
    access(1'b0, 32'h100, '0, 3, 1'b0);
    chk("first_rdata_model", m_data[0], 32'hDEAD_BEEF);
    idle(1'b0);
    access(1'b0, 32'h100, '0, 1, 1'b0);
    access(1'b1, 32'h100, 32'hCAFE_F00D, 2, 1'b0);
    access(1'b0, 32'h100, '0, 1, 1'b0);
    idle(1'b0);
    chk("store_hit_data", m_data[0], 32'hCAFE_F00D);

    // Cold store does not allocate; conflict eviction.
    access(1'b1, 32'h200, 32'h1111_2222, 1, 1'b0);
    access(1'b0, 32'h200, '0, 1, 1'b0);
    access(1'b0, 32'h140, '0, 2, 1'b0);
    access(1'b0, 32'h100, '0, 1, 1'b0);
    idle(1'b0);

    // Flush in idle, then flush coinciding with fill ack.
    access(1'b0, 32'h100, '0, 1, 1'b0);
    idle(1'b1);
    access(1'b0, 32'h100, '0, 2, 1'b0);
    access(1'b0, 32'h304, '0, 2, 1'b1);
    access(1'b0, 32'h304, '0, 1, 1'b0);
    idle(1'b0);

    // Reset while waiting in RD_MISS.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h180;
    @(negedge clk);
    #1;
    chk("rdmiss_memreq", {31'd0, bus.mem_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_memreq", {31'd0, bus.mem_req_o}, 32'd0);
    chk("async_rst_hits", bus.hit_cnt_o, 32'd0);
    chk("async_rst_miss", bus.miss_cnt_o, 32'd0);
    model_flush(); m_hits = '0; m_miss = '0;
    @(negedge clk);
    bus.req_i = 1'b0;
    rst = 1'b0;
    access(1'b0, 32'h180, '0, 1, 1'b0);
    idle(1'b0);

    // Random accesses over a small tag/index space to force hits and conflicts.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, NL - 1)), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) idle($urandom_range(0, 1) == 1);
      access($urandom_range(0, 3) == 0, a, $urandom, $urandom_range(1, 4),
             $urandom_range(0, 15) == 0);
    end
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
